// File: rtl/joy_debounce_events.sv
// Debounces a raw joystick button vector into clean levels and queues one
// {dir, idx} event per debounced press/release in a small FWFT FIFO.
module joy_debounce_events #(
  parameter int unsigned NBTN         = 12,
  parameter int unsigned DEBOUNCE_CYC = 5000,
  parameter int unsigned CNT_W        = 13,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          src_ready,
  input  logic [NBTN-1:0]               joy_raw,
  output logic [NBTN-1:0]               joy_state,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [4:0]                    ev_data,
  output logic                          ev_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned EV_W  = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [NBTN-1:0]  r_sync1, r_sync2;
  logic [NBTN-1:0]  r_state;
  logic [CNT_W-1:0] r_cnt [NBTN];
  logic [NBTN-1:0]  r_pend, r_pdir;
  logic             r_overflow;
  logic [EV_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_valid;
  logic [EV_W-1:0]  r_head;

  logic [NBTN-1:0]  w_state_n, w_toggle;
  logic [CNT_W-1:0] w_cnt_n [NBTN];
  logic [NBTN-1:0]  w_sel_oh, w_clr, w_pend_n, w_pdir_n;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_sel_dir, w_push, w_pop, w_lost;
  logic [EV_W-1:0]  w_push_data, w_head_n;
  logic [PTR_W-1:0] w_wr_n, w_rd_n;
  logic [LVL_W-1:0] w_level_n, w_remain;

  // Per-button debounce: count while the synced level disagrees with joy_state.
  always_comb begin
    w_state_n = r_state;
    w_toggle  = '0;
    for (int i = 0; i < int'(NBTN); i++) begin
      w_cnt_n[i] = '0;
      if (src_ready && (r_sync2[i] != r_state[i])) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_toggle[i]  = 1'b1;
          w_state_n[i] = r_sync2[i];
        end else begin
          w_cnt_n[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Lowest-index pending event wins; the descending scan leaves the lowest hit.
  always_comb begin
    w_sel_idx = '0;
    w_sel_oh  = '0;
    w_sel_dir = 1'b0;
    for (int i = int'(NBTN) - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel_idx   = IDX_W'(i);
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
        w_sel_dir   = r_pdir[i];
      end
    end
    w_push      = (|r_pend) && (r_level < LVL_FULL);
    w_push_data = {w_sel_dir, w_sel_idx};
    w_clr       = w_push ? w_sel_oh : '0;
  end

  // A new toggle on a still-pending button overwrites its direction.
  always_comb begin
    w_pend_n = (r_pend & ~w_clr) | w_toggle;
    w_lost   = |(w_toggle & r_pend & ~w_clr);
    for (int i = 0; i < int'(NBTN); i++) begin
      w_pdir_n[i] = w_toggle[i] ? w_state_n[i] : r_pdir[i];
    end
  end

  // FIFO bookkeeping; the head register holds the next word to present.
  always_comb begin
    w_pop     = r_valid & ev_ready;
    w_wr_n    = r_wr_ptr + PTR_W'(w_push);
    w_rd_n    = r_rd_ptr + PTR_W'(w_pop);
    w_level_n = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    w_remain  = r_level - LVL_W'(w_pop);
    w_head_n  = r_head;
    if (w_remain != '0) begin
      w_head_n = r_mem[w_rd_n];
    end else if (w_push) begin
      w_head_n = w_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_state    <= '0;
      r_pend     <= '0;
      r_pdir     <= '0;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_valid    <= 1'b0;
      r_head     <= '0;
      for (int i = 0; i < int'(NBTN); i++) r_cnt[i] <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else begin
      r_sync1    <= joy_raw;
      r_sync2    <= r_sync1;
      r_state    <= w_state_n;
      r_pend     <= w_pend_n;
      r_pdir     <= w_pdir_n;
      r_overflow <= r_overflow | w_lost;
      r_wr_ptr   <= w_wr_n;
      r_rd_ptr   <= w_rd_n;
      r_level    <= w_level_n;
      r_valid    <= (w_level_n != '0);
      r_head     <= w_head_n;
      for (int i = 0; i < int'(NBTN); i++) r_cnt[i] <= w_cnt_n[i];
      if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  assign joy_state   = r_state;
  assign ev_valid    = r_valid;
  assign ev_data     = r_head;
  assign ev_overflow = r_overflow;
  assign fifo_level  = r_level;

endmodule

// File: tb/tb_joy_debounce_events.sv
// Directed bench for joy_debounce_events with a scoreboard-driven event monitor.
module tb_joy_debounce_events;

  localparam int unsigned NBTN  = 12;
  localparam int unsigned DEB   = 4;
  localparam int unsigned DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              src_ready;
  logic [NBTN-1:0]   joy_raw;
  logic [NBTN-1:0]   joy_state;
  logic              ev_valid;
  logic              ev_ready;
  logic [4:0]        ev_data;
  logic              ev_overflow;
  logic [2:0]        fifo_level;

  int checks = 0;
  int errors = 0;
  logic [4:0] sb[$];

  always #5 clk = ~clk;

  joy_debounce_events #(
    .NBTN(NBTN), .DEBOUNCE_CYC(DEB), .CNT_W(3), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .src_ready(src_ready), .joy_raw(joy_raw),
    .joy_state(joy_state), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_data(ev_data), .ev_overflow(ev_overflow), .fifo_level(fifo_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_level(input string name, input int lvl, input int budget);
    int n = 0;
    while (int'(fifo_level) != lvl && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(fifo_level), 32'(lvl));
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || fifo_level != 0) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({name, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_state"}, 32'(joy_state), 32'd0);
    chk({name, "_valid"}, 32'(ev_valid), 32'd0);
    chk({name, "_data"}, 32'(ev_data), 32'd0);
    chk({name, "_ovf"}, 32'(ev_overflow), 32'd0);
    chk({name, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  // Every accepted handshake must match the oldest expected event.
  task automatic monitor();
    logic [4:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && ev_valid && ev_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", 32'(ev_data), 32'h3f);
        end else begin
          exp = sb.pop_front();
          chk("event_pop", 32'(ev_data), 32'(exp));
        end
      end
    end
  endtask

  task automatic main();
    // Reset
    rst = 1'b1; src_ready = 1'b0; joy_raw = '0; ev_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();
    check_all_zero("reset");

    // Test 1: button 3 press latency
    src_ready = 1'b1;
    joy_raw[3] = 1'b1;
    sb.push_back(5'b1_0011);
    tick(5);
    chk("t1_state_before", 32'(joy_state[3]), 32'd0);
    tick();
    chk("t1_state_at6", 32'(joy_state[3]), 32'd1);
    chk("t1_valid_not_yet", 32'(ev_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(ev_valid), 32'd1);
    chk("t1_data", 32'(ev_data), 32'h13);
    chk("t1_level", 32'(fifo_level), 32'd1);
    ev_ready = 1'b1;
    drain("t1", 20);

    // Test 2: 3-cycle glitch on button 5
    joy_raw[5] = 1'b1;
    tick(3);
    joy_raw[5] = 1'b0;
    tick(10);
    chk("t2_state", 32'(joy_state), 32'h008);
    chk("t2_level", 32'(fifo_level), 32'd0);
    chk("t2_valid", 32'(ev_valid), 32'd0);

    // Test 3: simultaneous presses of 0, 7, 11 pop in index order
    joy_raw = joy_raw | 12'h881;
    sb.push_back(5'h10); sb.push_back(5'h17); sb.push_back(5'h1b);
    tick(7);
    chk("t3_data0", 32'(ev_data), 32'h10);
    chk("t3_valid0", 32'(ev_valid), 32'd1);
    tick();
    chk("t3_data1", 32'(ev_data), 32'h17);
    tick();
    chk("t3_data2", 32'(ev_data), 32'h1b);
    tick();
    chk("t3_empty", 32'(ev_valid), 32'd0);
    chk("t3_state", 32'(joy_state), 32'h889);

    // Test 4: six toggles with consumer stalled
    ev_ready = 1'b0;
    joy_raw = joy_raw ^ 12'h0db;
    sb.push_back(5'h00); sb.push_back(5'h11); sb.push_back(5'h03);
    sb.push_back(5'h14); sb.push_back(5'h16); sb.push_back(5'h07);
    tick(12);
    chk("t4_level_sat", 32'(fifo_level), 32'd4);
    chk("t4_head", 32'(ev_data), 32'h00);
    tick(3);
    chk("t4_head_stable", 32'(ev_data), 32'h00);
    chk("t4_state", 32'(joy_state), 32'h852);
    ev_ready = 1'b1;
    drain("t4", 40);
    chk("t4_ovf", 32'(ev_overflow), 32'd0);

    // Test 5: double toggle of button 2 while FIFO full
    ev_ready = 1'b0;
    joy_raw = '0;
    sb.push_back(5'h01); sb.push_back(5'h04); sb.push_back(5'h06); sb.push_back(5'h0b);
    wait_level("t5_fill", 4, 40);
    joy_raw[2] = 1'b1;
    tick(8);
    chk("t5_press", 32'(joy_state[2]), 32'd1);
    chk("t5_ovf_before", 32'(ev_overflow), 32'd0);
    joy_raw[2] = 1'b0;
    tick(8);
    chk("t5_release", 32'(joy_state[2]), 32'd0);
    chk("t5_ovf", 32'(ev_overflow), 32'd1);
    chk("t5_level", 32'(fifo_level), 32'd4);
    sb.push_back(5'h02);
    ev_ready = 1'b1;
    drain("t5", 40);
    chk("t5_ovf_sticky", 32'(ev_overflow), 32'd1);

    // Test 6: reset mid-debounce with 3 queued events
    ev_ready = 1'b0;
    joy_raw = 12'h007;
    wait_level("t6_fill", 3, 40);
    joy_raw[5] = 1'b1;
    tick(3);
    rst = 1'b1;
    tick();
    check_all_zero("t6_rst");
    rst = 1'b0;
    src_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      joy_raw = ~joy_raw;
      tick(2);
    end
    joy_raw = 12'hfff;
    tick(12);
    check_all_zero("t6_noready");
    chk("t6_sb", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      main();
    join_any
  end

endmodule
